mul_rs_issue: RTL



---
 rtl/tomasulo_pkg.sv | 39 +++
 rtl/mul_rs_pick.sv | 28 ++
 rtl/mul_rs_issue.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the multiply/divide reservation station.
package tomasulo_pkg;

    localparam int RS_DEPTH = 3;
    localparam int RS_DW    = 8;
    localparam int RS_TW    = 3;
    localparam int RS_RW    = 4;
    localparam int RS_FW    = 4;
    localparam int RS_IW    = 3;
    localparam int RS_AW    = $clog2(RS_DEPTH + 1);

    localparam logic [RS_FW-1:0] FUNC_MUL = 4'b0010;
    localparam logic [RS_FW-1:0] FUNC_DIV = 4'b0011;

    typedef struct packed {
        logic             valid;
        logic             issued;
        logic [RS_FW-1:0] func;
        logic [RS_RW-1:0] rd;
        logic [RS_TW-1:0] rob;
        logic             v1;
        logic [RS_DW-1:0] d1;
        logic [RS_TW-1:0] q1;
        logic             v2;
        logic [RS_DW-1:0] d2;
        logic [RS_TW-1:0] q2;
        logic [RS_AW-1:0] age;
    } rs_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic func_legal(input logic [RS_FW-1:0] f);
        return (f == FUNC_MUL) || (f == FUNC_DIV);
    endfunction

endpackage

// File: rtl/mul_rs_pick.sv
// Combinational selector: returns the eligible entry with the smallest age.
module mul_rs_pick #(
    parameter int DEPTH = 3,
    parameter int AW    = 2,
    parameter int IW    = 3
) (
    input  logic [DEPTH-1:0]         i_elig,
    input  logic [DEPTH-1:0][AW-1:0] i_age,
    output logic                     o_found,
    output logic [IW-1:0]            o_index
);

    logic [AW-1:0] w_best;

    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_best  = '1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_elig[i] && (!o_found || (i_age[i] < w_best))) begin
                o_found = 1'b1;
                o_index = IW'(i);
                w_best  = i_age[i];
            end
        end
    end

endmodule

// File: rtl/mul_rs_issue.sv
// Reservation station and issue controller for the mul/div execution unit.
// Holds dispatched ops, captures CDB operands and issues the oldest ready entry.
module mul_rs_issue
    import tomasulo_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int DW    = RS_DW,
    parameter int TW    = RS_TW,
    parameter int RW    = RS_RW
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          flush,
    input  logic          disp_valid,
    output logic          disp_ready,
    input  logic [3:0]    disp_func,
    input  logic [RW-1:0] disp_rd,
    input  logic [TW-1:0] disp_rob,
    input  logic          disp_v1,
    input  logic          disp_v2,
    input  logic [DW-1:0] disp_d1,
    input  logic [DW-1:0] disp_d2,
    input  logic [TW-1:0] disp_q1,
    input  logic [TW-1:0] disp_q2,
    input  logic          cdb_valid,
    input  logic [TW-1:0] cdb_tag,
    input  logic [15:0]   cdb_data,
    output logic          ex_b,
    output logic [2:0]    rs_index,
    output logic [DW-1:0] rs1_data,
    output logic [DW-1:0] rs2_data,
    output logic [3:0]    func,
    output logic [TW-1:0] rob_ind,
    output logic [RW-1:0] rd,
    input  logic          ex_done,
    input  logic [2:0]    ex_done_index,
    output logic          err
);

    localparam int AW = RS_AW;

    rs_entry_t r_ent     [DEPTH];
    rs_entry_t w_ent_nxt [DEPTH];
    rs_entry_t w_sel;
    rs_entry_t w_new;
    state_t    r_state;
    state_t    w_state_nxt;

    logic [DEPTH-1:0]         w_elig;
    logic [DEPTH-1:0][AW-1:0] w_age;
    logic                     w_found;
    logic [2:0]               w_pick;
    logic                     w_any_free;
    logic [2:0]               w_alloc;
    logic [AW-1:0]            w_count;
    logic [AW-1:0]            w_free_age;
    logic                     w_disp_fire;
    logic                     w_disp_ok;
    logic                     w_issue;
    logic                     w_free;
    logic                     w_err_set;
    logic                     w_unused_cdb;

    logic          r_ex_b;
    logic [2:0]    r_rs_index;
    logic [DW-1:0] r_rs1_data;
    logic [DW-1:0] r_rs2_data;
    logic [3:0]    r_func;
    logic [TW-1:0] r_rob_ind;
    logic [RW-1:0] r_rd;
    logic          r_err;

    assign w_unused_cdb = ^cdb_data[15:DW];

    // Occupancy from registered state only; lowest free index wins allocation.
    always_comb begin
        w_any_free = 1'b0;
        w_alloc    = '0;
        w_count    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_ent[i].valid) begin
                w_count = w_count + AW'(1);
            end else begin
                w_any_free = 1'b1;
                w_alloc    = 3'(i);
            end
        end
    end

    assign disp_ready  = w_any_free;
    assign w_disp_fire = disp_valid && w_any_free && !flush;
    assign w_disp_ok   = w_disp_fire && func_legal(disp_func);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_elig[i] = r_ent[i].valid && !r_ent[i].issued && r_ent[i].v1 && r_ent[i].v2;
            w_age[i]  = r_ent[i].age;
        end
    end

    mul_rs_pick #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (3)
    ) u_pick (
        .i_elig  (w_elig),
        .i_age   (w_age),
        .o_found (w_found),
        .o_index (w_pick)
    );

    always_comb begin
        w_sel      = '0;
        w_free_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (3'(i) == w_pick)     w_sel      = r_ent[i];
            if (3'(i) == r_rs_index) w_free_age = r_ent[i].age;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_free      = 1'b0;
        w_err_set   = 1'b0;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        w_issue     = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                    if (ex_done) w_err_set = 1'b1;
                end
                ST_BUSY: begin
                    if (ex_done) begin
                        if (ex_done_index == r_rs_index) begin
                            w_free      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_err_set = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
            if (w_disp_fire && !func_legal(disp_func)) w_err_set = 1'b1;
        end
    end

    // A same-cycle free shrinks the population, so the newcomer's age drops too.
    always_comb begin
        w_new       = '0;
        w_new.valid = 1'b1;
        w_new.func  = disp_func;
        w_new.rd    = disp_rd;
        w_new.rob   = disp_rob;
        w_new.v1    = disp_v1;
        w_new.d1    = disp_d1;
        w_new.q1    = disp_q1;
        w_new.v2    = disp_v2;
        w_new.d2    = disp_d2;
        w_new.q2    = disp_q2;
        if (!disp_v1 && cdb_valid && (disp_q1 == cdb_tag)) begin
            w_new.v1 = 1'b1;
            w_new.d1 = cdb_data[DW-1:0];
        end
        if (!disp_v2 && cdb_valid && (disp_q2 == cdb_tag)) begin
            w_new.v2 = 1'b1;
            w_new.d2 = cdb_data[DW-1:0];
        end
        w_new.age = w_free ? (w_count - AW'(1)) : w_count;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ent_nxt[i] = r_ent[i];
            if (r_ent[i].valid) begin
                if (!r_ent[i].v1 && cdb_valid && (r_ent[i].q1 == cdb_tag)) begin
                    w_ent_nxt[i].v1 = 1'b1;
                    w_ent_nxt[i].d1 = cdb_data[DW-1:0];
                end
                if (!r_ent[i].v2 && cdb_valid && (r_ent[i].q2 == cdb_tag)) begin
                    w_ent_nxt[i].v2 = 1'b1;
                    w_ent_nxt[i].d2 = cdb_data[DW-1:0];
                end
                if (w_issue && (3'(i) == w_pick)) w_ent_nxt[i].issued = 1'b1;
                if (w_free) begin
                    if (3'(i) == r_rs_index) begin
                        w_ent_nxt[i] = '0;
                    end else if (r_ent[i].age > w_free_age) begin
                        w_ent_nxt[i].age = r_ent[i].age - AW'(1);
                    end
                end
            end
            if (w_disp_ok && (3'(i) == w_alloc)) w_ent_nxt[i] = w_new;
            if (flush) w_ent_nxt[i] = '0;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_ent_nxt[i];
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_ex_b     <= 1'b0;
            r_rs_index <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_func     <= '0;
            r_rob_ind  <= '0;
            r_rd       <= '0;
            r_err      <= 1'b0;
        end else begin
            r_ex_b <= w_issue;
            if (w_issue) begin
                r_rs_index <= w_pick;
                r_rs1_data <= w_sel.d1;
                r_rs2_data <= w_sel.d2;
                r_func     <= w_sel.func;
                r_rob_ind  <= w_sel.rob;
                r_rd       <= w_sel.rd;
            end
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign ex_b     = r_ex_b;
    assign rs_index = r_rs_index;
    assign rs1_data = r_rs1_data;
    assign rs2_data = r_rs2_data;
    assign func     = r_func;
    assign rob_ind  = r_rob_ind;
    assign rd       = r_rd;
    assign err      = r_err;

endmodule
